// File: rtl/nearest_value_tracker.sv
// Tracks the sample closest to a latched reference over a programmed-length stream,
// reporting the winning value, its distance and its stream position.
module nearest_value_tracker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] reff,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             busy,
  output logic             done,
  output logic             no_data,
  output logic [WIDTH-1:0] best,
  output logic [WIDTH-1:0] best_dist,
  output logic [CNT_W-1:0] best_index
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_reff;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_total;
  logic             r_busy;
  logic             r_done;
  logic             r_no_data;
  logic [WIDTH-1:0] r_best;
  logic [WIDTH-1:0] r_best_dist;
  logic [CNT_W-1:0] r_best_index;

  logic [WIDTH-1:0] w_dist;
  logic             w_take;
  logic             w_last;

  always_comb begin
    w_dist = (din >= r_reff) ? (din - r_reff) : (r_reff - din);
    // First sample always loads; later ones must be strictly closer so ties keep the earlier.
    w_take = (r_count == '0) || (w_dist < r_best_dist);
    w_last = (r_count == (r_total - 1'b1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_reff       <= '0;
      r_count      <= '0;
      r_total      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_no_data    <= 1'b0;
      r_best       <= '0;
      r_best_dist  <= '1;
      r_best_index <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_reff  <= reff;
            r_total <= num_samples;
            r_count <= '0;
            if (num_samples == '0) begin
              r_state   <= StFin;
              r_done    <= 1'b1;
              r_no_data <= 1'b1;
            end else begin
              r_state   <= StRun;
              r_busy    <= 1'b1;
              r_no_data <= 1'b0;
            end
          end
        end
        StRun: begin
          if (din_valid) begin
            if (w_take) begin
              r_best       <= din;
              r_best_dist  <= w_dist;
              r_best_index <= r_count;
            end
            r_count <= r_count + 1'b1;
            if (w_last) begin
              r_state <= StFin;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        StFin: begin
          r_state   <= StIdle;
          r_done    <= 1'b0;
          r_no_data <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign no_data    = r_no_data;
  assign best       = r_best;
  assign best_dist  = r_best_dist;
  assign best_index = r_best_index;

endmodule

// File: tb/tb_nearest_value_tracker.sv
// Directed vector bench for nearest_value_tracker: table-driven searches plus
// hand-written sequences for zero-length, ignored inputs and mid-run reset.
module tb_nearest_value_tracker;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] reff;
  logic [7:0] num_samples;
  logic [7:0] din;
  logic       din_valid;
  logic       busy;
  logic       done;
  logic       no_data;
  logic [7:0] best;
  logic [7:0] best_dist;
  logic [7:0] best_index;

  int n_checks = 0;
  int n_pass   = 0;

  nearest_value_tracker #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reff       (reff),
    .num_samples(num_samples),
    .din        (din),
    .din_valid  (din_valid),
    .busy       (busy),
    .done       (done),
    .no_data    (no_data),
    .best       (best),
    .best_dist  (best_dist),
    .best_index (best_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [7:0]      r;
    logic [7:0]      n;
    logic [3:0][7:0] smp;
    int              gap;
    logic [7:0]      eb;
    logic [7:0]      ed;
    logic [7:0]      ei;
  } vec_t;

  vec_t vecs [0:5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge with the DUT idle; returns likewise.
  task automatic run_search(input vec_t v);
    start       = 1'b1;
    reff        = v.r;
    num_samples = v.n;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(v.n); i++) begin
      if (i == 1) begin
        for (int g = 0; g < v.gap; g++) begin
          din       = 8'hAA;
          din_valid = 1'b0;
          tick();
          chk({v.name, " gap busy/done"}, {30'd0, busy, done}, 32'd2);
        end
      end
      chk({v.name, " run busy/done"}, {30'd0, busy, done}, 32'd2);
      din       = v.smp[i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    chk({v.name, " done"}, {29'd0, done, busy, no_data}, 32'd4);
    chk({v.name, " best"}, best, v.eb);
    chk({v.name, " best_dist"}, best_dist, v.ed);
    chk({v.name, " best_index"}, best_index, v.ei);
    tick();
    chk({v.name, " done one-shot"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{"basic", 8'd100, 8'd4, {8'd99, 8'd130, 8'd105, 8'd90}, 0, 8'd99, 8'd1, 8'd3};
    vecs[1] = '{"tie", 8'd50, 8'd3, {8'd0, 8'd60, 8'd55, 8'd45}, 0, 8'd45, 8'd5, 8'd0};
    vecs[2] = '{"gap", 8'd0, 8'd2, {8'd0, 8'd0, 8'd0, 8'd255}, 2, 8'd0, 8'd0, 8'd1};
    vecs[3] = '{"max_dist", 8'd255, 8'd1, {8'd9, 8'd9, 8'd9, 8'd0}, 0, 8'd0, 8'd255, 8'd0};
    vecs[4] = '{"descending", 8'd128, 8'd3, {8'd0, 8'd190, 8'd60, 8'd200}, 0, 8'd190, 8'd62, 8'd2};
    vecs[5] = '{"exact_tie", 8'd10, 8'd2, {8'd0, 8'd0, 8'd10, 8'd10}, 0, 8'd10, 8'd0, 8'd0};

    rst = 1'b1; start = 1'b0; reff = '0; num_samples = '0; din = '0; din_valid = 1'b0;
    tick();
    tick();
    chk("reset busy/done/no_data", {29'd0, busy, done, no_data}, 32'd0);
    chk("reset best", best, 32'd0);
    chk("reset best_dist", best_dist, 32'd255);
    chk("reset best_index", best_index, 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) run_search(vecs[k]);

    // Zero-length search: results from the previous search (10,0,0) must persist.
    start = 1'b1; reff = 8'd77; num_samples = 8'd0;
    tick();
    start = 1'b0;
    chk("zero done/busy/no_data", {29'd0, done, busy, no_data}, 32'd5);
    chk("zero best held", {best, best_dist, best_index}, {8'd0, 8'd10, 8'd0, 8'd0});
    tick();
    chk("zero done/no_data cleared", {29'd0, done, busy, no_data}, 32'd0);

    // din_valid while idle is ignored.
    for (int i = 0; i < 3; i++) begin
      din = 8'd10; din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    chk("idle valid ignored", {8'd0, best, best_dist, best_index}, {8'd0, 8'd10, 8'd0, 8'd0});
    chk("idle valid busy/done", {30'd0, busy, done}, 32'd0);

    // Start re-asserted mid-run with a new reference must have no effect.
    start = 1'b1; reff = 8'd100; num_samples = 8'd3;
    tick();
    din = 8'd101; din_valid = 1'b1; reff = 8'd10; num_samples = 8'd1;
    tick();
    din = 8'd12;
    tick();
    start = 1'b0;
    din = 8'd105;
    tick();
    din_valid = 1'b0;
    chk("ignored start done", {30'd0, done, busy}, 32'd2);
    chk("ignored start result", {8'd0, best, best_dist, best_index}, {8'd0, 8'd101, 8'd1, 8'd0});
    tick();

    // Reset after 2 of 5 samples.
    start = 1'b1; reff = 8'd0; num_samples = 8'd5;
    tick();
    start = 1'b0;
    din = 8'd3; din_valid = 1'b1;
    tick();
    din = 8'd4;
    tick();
    rst = 1'b1; din = 8'd1;
    tick();
    rst = 1'b0; din_valid = 1'b0;
    chk("midrst busy/done", {30'd0, busy, done}, 32'd0);
    chk("midrst result", {8'd0, best, best_dist, best_index}, {8'd0, 8'd0, 8'd255, 8'd0});
    tick();
    chk("midrst no late done", {30'd0, busy, done}, 32'd0);
    run_search(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
